// File: rtl/fft_stage_sequencer_if.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer_if
// Handshake and mux-select bundle between an FFT controller (master) and the
// stage sequencer (slave).
//   start/inverse/en/abort : master -> sequencer control
//   busy/done              : sequencer status
//   sel_valid/sel_stage/sel_cnt : registered slot decode, one cycle after issue
//   m0_s..m3_s             : registered datapath mux selects for that slot
// ---------------------------------------------------------------------------
interface fft_stage_sequencer_if #(
  parameter int CNT_W = 3,
  parameter int STG_W = 4
);
  logic             start;
  logic             inverse;
  logic             en;
  logic             abort;
  logic             busy;
  logic             done;
  logic             sel_valid;
  logic [STG_W-1:0] sel_stage;
  logic [CNT_W-1:0] sel_cnt;
  logic             m0_s;
  logic [1:0]       m1_s;
  logic             m2_s;
  logic             m3_s;

  modport master (
    output start, inverse, en, abort,
    input  busy, done, sel_valid, sel_stage, sel_cnt, m0_s, m1_s, m2_s, m3_s
  );

  modport slave (
    input  start, inverse, en, abort,
    output busy, done, sel_valid, sel_stage, sel_cnt, m0_s, m1_s, m2_s, m3_s
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer
// Control sequencer for an iterative radix-2 FFT of 2^NUMSTAGES points.
// Walks NUMSTAGES stages of 2^CNT_W butterfly slots, issuing one slot per
// RUN cycle with en=1, and registers the slot decode (stage, counter and the
// m0..m3 datapath selects) one cycle after issue.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of fft_stage_sequencer_if (start/inverse/en/abort in;
//           busy/done/sel_* and m0_s..m3_s out, all registered)
// ---------------------------------------------------------------------------
module fft_stage_sequencer #(
  parameter int NUMSTAGES = 5,
  parameter int CNT_W     = NUMSTAGES - 2,
  parameter int STG_W     = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  fft_stage_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUMSTAGES - 1);
  localparam logic [STG_W-1:0] M3_STAGE   = STG_W'(NUMSTAGES - 2);
  localparam logic [STG_W-1:0] CNT_W_STG  = STG_W'(CNT_W);

  state_t           r_state;
  logic [STG_W-1:0] r_stage;
  logic [CNT_W-1:0] r_cnt;
  logic             r_inv;
  logic             r_busy;
  logic             r_done;
  logic             r_sel_valid;
  logic [STG_W-1:0] r_sel_stage;
  logic [CNT_W-1:0] r_sel_cnt;
  logic             r_m0;
  logic [1:0]       r_m1;
  logic             r_m2;
  logic             r_m3;

  logic             w_issue;
  logic             w_cnt_last;
  logic             w_stage_last;
  logic [3:0]       w_dec;
  logic             w_m0;

  // Decode of slot (s, c) into {m1[1:0], m2, m3}. The field F is the top s
  // bits of the counter, obtained by right-shifting away the low CNT_W-s bits.
  // For the first and last stages the shift amount is irrelevant because
  // those stages ignore F.
  function automatic logic [3:0] decode_slot(input logic [STG_W-1:0] s,
                                             input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] f;
    logic [1:0]       m1;
    logic             m2;
    logic             m3;
    f = c >> (CNT_W_STG - s);
    if (s == {STG_W{1'b0}}) begin
      m1 = 2'b11;
      m2 = 1'b0;
    end else if (s == LAST_STAGE) begin
      m1 = 2'b00;
      m2 = 1'b1;
    end else if (f == {CNT_W{1'b0}}) begin
      m1 = 2'b00;
      m2 = 1'b1;
    end else if (f[0]) begin
      m1 = 2'b01;
      m2 = 1'b0;
    end else begin
      m1 = 2'b10;
      m2 = 1'b1;
    end
    m3 = (s >= M3_STAGE);
    return {m1, m2, m3};
  endfunction

  // A slot issues on every enabled RUN cycle; an abort in the same cycle does
  // not cancel it, it only stops further issue.
  assign w_issue      = (r_state == S_RUN) && bus.en;
  assign w_cnt_last   = (r_cnt == {CNT_W{1'b1}});
  assign w_stage_last = (r_stage == LAST_STAGE);
  assign w_dec        = decode_slot(r_stage, r_cnt);
  // Conjugate/bypass is only applied on the first and last stages.
  assign w_m0         = r_inv && ((r_stage == {STG_W{1'b0}}) || w_stage_last);

  // Stage FSM, butterfly counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_stage     <= {STG_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_inv       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sel_valid <= 1'b0;
      r_sel_stage <= {STG_W{1'b0}};
      r_sel_cnt   <= {CNT_W{1'b0}};
      r_m0        <= 1'b0;
      r_m1        <= 2'b00;
      r_m2        <= 1'b0;
      r_m3        <= 1'b0;
    end else begin
      // Slot decode pipeline: selects hold their last value when idle.
      r_sel_valid <= w_issue;
      if (w_issue) begin
        r_sel_stage <= r_stage;
        r_sel_cnt   <= r_cnt;
        r_m0        <= w_m0;
        r_m1        <= w_dec[3:2];
        r_m2        <= w_dec[1];
        r_m3        <= w_dec[0];
      end

      if (bus.abort) begin
        // Abort wins over start and suppresses the done pulse.
        r_state <= S_IDLE;
        r_stage <= {STG_W{1'b0}};
        r_cnt   <= {CNT_W{1'b0}};
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_done <= 1'b0;
            if (bus.start) begin
              r_state <= S_RUN;
              r_stage <= {STG_W{1'b0}};
              r_cnt   <= {CNT_W{1'b0}};
              r_inv   <= bus.inverse;
              r_busy  <= 1'b1;
            end else begin
              r_busy  <= 1'b0;
            end
          end
          S_RUN: begin
            if (bus.en) begin
              if (w_cnt_last) begin
                r_cnt <= {CNT_W{1'b0}};
                if (w_stage_last) begin
                  // done lands together with the last slot's sel_valid.
                  r_state <= S_DONE;
                  r_stage <= {STG_W{1'b0}};
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end else begin
                  r_stage <= r_stage + {{(STG_W-1){1'b0}}, 1'b1};
                end
              end else begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_stage <= {STG_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sel_valid = r_sel_valid;
  assign bus.sel_stage = r_sel_stage;
  assign bus.sel_cnt   = r_sel_cnt;
  assign bus.m0_s      = r_m0;
  assign bus.m1_s      = r_m1;
  assign bus.m2_s      = r_m2;
  assign bus.m3_s      = r_m3;

endmodule
